// File: rtl/nco_multi.sv
// Multi-channel numerically controlled oscillator.
// Each channel owns a phase accumulator plus a small waveform shaper
// (saw, square, triangle, inverted saw). Channels share one advance
// enable and one phase-sync strobe; configuration is written one
// channel at a time through a shared write port.
module nco_multi #(
    parameter int W   = 10,   // phase accumulator width
    parameter int DW  = 8,    // phase increment width (DW <= W)
    parameter int OW  = 7,    // output sample width (2 <= OW <= W)
    parameter int NCH = 2     // channel count (1..16)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_ce,
    input  logic                i_sync,
    input  logic                i_ld,
    input  logic [3:0]          i_ch,
    input  logic [DW-1:0]       i_dphase,
    input  logic [1:0]          i_mode,
    input  logic [OW-1:0]       i_duty,
    output logic [NCH*OW-1:0]   o_val,
    output logic [NCH-1:0]      o_wrap
);

    // Waveform mode encodings
    localparam logic [1:0] MODE_SAW  = 2'd0;
    localparam logic [1:0] MODE_SQR  = 2'd1;
    localparam logic [1:0] MODE_TRI  = 2'd2;
    localparam logic [1:0] MODE_ISAW = 2'd3;

    // Square threshold after reset sits at mid-scale (50 % duty)
    localparam logic [OW-1:0] DUTY_RESET = OW'(1) << (OW - 1);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [W-1:0]  acc_reg;
            logic [DW-1:0] dph_reg;
            logic [1:0]    mode_reg;
            logic [OW-1:0] duty_reg;
            logic [OW-1:0] val_reg;
            logic          wrap_reg;

            logic [W:0]    sum;
            logic          ld_hit;
            logic [OW-1:0] phase_top;
            logic [OW-1:0] tri_ramp;
            logic [OW-1:0] val_next;

            // A write addressed to an index beyond NCH never matches any channel,
            // so out-of-range writes fall away naturally.
            assign ld_hit = i_ld && (i_ch == 4'(gi));

            // One extra bit keeps the carry out of the accumulator for the wrap flag
            assign sum = {1'b0, acc_reg} + (W+1)'(dph_reg);

            // Shaper operands: top OW phase bits and the doubled ramp for triangle
            assign phase_top = acc_reg[W-1 -: OW];
            assign tri_ramp  = {phase_top[OW-2:0], 1'b0};

            // Waveform shaper evaluated on the current (pre-advance) phase
            always_comb begin
                val_next = '0;
                case (mode_reg)
                    MODE_SAW:  val_next = phase_top;
                    MODE_SQR:  val_next = (phase_top < duty_reg) ? '1 : '0;
                    MODE_TRI:  val_next = phase_top[OW-1] ? ~tri_ramp : tri_ramp;
                    MODE_ISAW: val_next = ~phase_top;
                    default:   val_next = '0;
                endcase
            end

            // Configuration registers: loaded by a matching write strobe
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    dph_reg  <= '0;
                    mode_reg <= MODE_SAW;
                    duty_reg <= DUTY_RESET;
                end else if (ld_hit) begin
                    dph_reg  <= i_dphase;
                    mode_reg <= i_mode;
                    duty_reg <= i_duty;
                end
            end

            // Phase accumulator and wrap strobe; sync has priority over advance.
            // The add uses the increment held before this edge, so a fresh
            // write only takes effect from the following edge.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    acc_reg  <= '0;
                    wrap_reg <= 1'b0;
                end else if (i_sync) begin
                    acc_reg  <= '0;
                    wrap_reg <= 1'b0;
                end else if (i_ce) begin
                    acc_reg  <= sum[W-1:0];
                    wrap_reg <= sum[W];
                end else begin
                    wrap_reg <= 1'b0;
                end
            end

            // Output sample register, updated every clock regardless of advance
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    val_reg <= '0;
                end else begin
                    val_reg <= val_next;
                end
            end

            assign o_val[gi*OW +: OW] = val_reg;
            assign o_wrap[gi]         = wrap_reg;
        end
    endgenerate

endmodule

// File: tb/tb_nco_multi.sv
// Directed plus short random bench for nco_multi (default parameters).
// A reference model predicts each cycle's outputs when the stimulus is
// driven; predictions are queued and checked after the clock edge.
module tb_nco_multi;

    localparam int W   = 10;
    localparam int DW  = 8;
    localparam int OW  = 7;
    localparam int NCH = 2;
    localparam int VW  = NCH * OW;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b0;
    logic              i_ce = 1'b0;
    logic              i_sync = 1'b0;
    logic              i_ld = 1'b0;
    logic [3:0]        i_ch = '0;
    logic [DW-1:0]     i_dphase = '0;
    logic [1:0]        i_mode = '0;
    logic [OW-1:0]     i_duty = '0;
    logic [VW-1:0]     o_val;
    logic [NCH-1:0]    o_wrap;

    int total = 0;
    int bad = 0;

    // Reference state
    int m_acc  [NCH];
    int m_dph  [NCH];
    int m_mode [NCH];
    int m_duty [NCH];

    // Scoreboard queues
    logic [VW-1:0]  exp_val_q  [$];
    logic [NCH-1:0] exp_wrap_q [$];

    nco_multi #(.W(W), .DW(DW), .OW(OW), .NCH(NCH)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_ce     (i_ce),
        .i_sync   (i_sync),
        .i_ld     (i_ld),
        .i_ch     (i_ch),
        .i_dphase (i_dphase),
        .i_mode   (i_mode),
        .i_duty   (i_duty),
        .o_val    (o_val),
        .o_wrap   (o_wrap)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Waveform per the shaper definition, written arithmetically
    function automatic int shape(input int acc, input int mode, input int duty);
        int p;
        p = (acc >> (W - OW)) % (1 << OW);
        case (mode)
            0: return p;
            1: return (p < duty) ? 127 : 0;
            2: return (p < 64) ? 2 * p : 255 - 2 * p;
            default: return 127 - p;
        endcase
    endfunction

    // Predict, advance the model, clock once, then check the outputs
    task automatic step();
        logic [VW-1:0]  ev;
        logic [NCH-1:0] ew;
        logic [VW-1:0]  got_v;
        logic [NCH-1:0] got_w;
        int s;
        ev = '0;
        ew = '0;
        for (int c = 0; c < NCH; c++) begin
            if (!i_reset) ev[c*OW +: OW] = OW'(shape(m_acc[c], m_mode[c], m_duty[c]));
        end
        if (i_reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_acc[c] = 0; m_dph[c] = 0; m_mode[c] = 0; m_duty[c] = 64;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                s = m_acc[c] + m_dph[c];
                if (i_sync) m_acc[c] = 0;
                else if (i_ce) begin
                    m_acc[c] = s % (1 << W);
                    ew[c] = (s >= (1 << W));
                end
            end
            if (i_ld && (int'(i_ch) < NCH)) begin
                m_dph[i_ch]  = int'(i_dphase);
                m_mode[i_ch] = int'(i_mode);
                m_duty[i_ch] = int'(i_duty);
            end
        end
        exp_val_q.push_back(ev);
        exp_wrap_q.push_back(ew);
        @(posedge i_clk);
        #1;
        got_v = exp_val_q.pop_front();
        got_w = exp_wrap_q.pop_front();
        chk("sb_val", 32'(o_val), 32'(got_v));
        chk("sb_wrap", 32'(o_wrap), 32'(got_w));
    endtask

    // One-cycle configuration write
    task automatic cfg(input int ch, input int dph, input int mode, input int duty);
        $display("write ch=%0d dph=%0d mode=%0d duty=%0d", ch, dph, mode, duty);
        i_ld = 1'b1; i_ch = 4'(ch); i_dphase = DW'(dph); i_mode = 2'(mode); i_duty = OW'(duty);
        step();
        i_ld = 1'b0;
    endtask

    initial begin
        int wraps;
        int ones;
        int nz;
        int sum;
        int zeros;
        int peaks;
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0; m_dph[c] = 0; m_mode[c] = 0; m_duty[c] = 64;
        end

        // Reset
        $display("phase reset");
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
        chk("reset_val", 32'(o_val), 32'd0);
        chk("reset_wrap", 32'(o_wrap), 32'd0);

        // Saw on ch0, dph=1
        cfg(0, 1, 0, 0);
        i_ce = 1'b1;
        wraps = 0; nz = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (o_wrap[0]) wraps++;
            if (o_val[OW +: OW] != 0) nz++;
        end
        $display("phase saw wraps=%0d", wraps);
        chk("saw_wraps", 32'(wraps), 32'd1);
        chk("saw_ch1_zero", 32'(nz), 32'd0);

        // Square on ch0 with simultaneous sync restart
        i_sync = 1'b1;
        cfg(0, 8, 1, 32);
        i_sync = 1'b0;
        for (int i = 0; i < 4; i++) step();
        ones = 0; wraps = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (o_val[0 +: OW] == 7'd127) ones++;
            if (o_wrap[0]) wraps++;
        end
        $display("phase square high=%0d wraps=%0d", ones, wraps);
        chk("sqr_high", 32'(ones), 32'd64);
        chk("sqr_wraps", 32'(wraps), 32'd2);

        // Triangle on ch1
        cfg(1, 8, 2, 0);
        for (int i = 0; i < 4; i++) step();
        sum = 0; zeros = 0; peaks = 0;
        for (int i = 0; i < 128; i++) begin
            step();
            sum += int'(o_val[OW +: OW]);
            if (o_val[OW +: OW] == 7'd0) zeros++;
            if (o_val[OW +: OW] == 7'd127) peaks++;
        end
        $display("phase triangle sum=%0d", sum);
        chk("tri_sum", 32'(sum), 32'd8128);
        chk("tri_zero", 32'(zeros), 32'd1);
        chk("tri_peak", 32'(peaks), 32'd1);

        // Control: ch0 saw at dph=8, hold, sync, ignored write
        cfg(0, 8, 0, 0);
        for (int i = 0; i < 20; i++) step();
        i_ce = 1'b0;
        wraps = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_wrap != 0) wraps++;
        end
        chk("hold_wraps", 32'(wraps), 32'd0);
        i_ce = 1'b1;
        i_sync = 1'b1;
        $display("phase sync");
        step();
        i_sync = 1'b0;
        step();
        chk("sync_ch0_zero", 32'(o_val[0 +: OW]), 32'd0);
        cfg(2, 200, 3, 5);
        for (int i = 0; i < 20; i++) step();

        // Mid-run reset with both channels active
        $display("phase midrun reset");
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("mid_reset_val", 32'(o_val), 32'd0);
        chk("mid_reset_wrap", 32'(o_wrap), 32'd0);
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_val != 0) nz++;
        end
        chk("post_reset_idle", 32'(nz), 32'd0);

        // Randomised mix of writes, syncs, enables and occasional resets
        $display("phase random");
        for (int i = 0; i < 400; i++) begin
            i_ce     = 1'($urandom_range(0, 3) != 0);
            i_sync   = 1'($urandom_range(0, 15) == 0);
            i_ld     = 1'($urandom_range(0, 7) == 0);
            i_reset  = 1'($urandom_range(0, 63) == 0);
            i_ch     = 4'($urandom_range(0, 3));
            i_dphase = DW'($urandom);
            i_mode   = 2'($urandom);
            i_duty   = OW'($urandom);
            step();
        end
        i_ld = 1'b0; i_sync = 1'b0; i_reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
